pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_pkg.sv | 18 +
 rtl/pll_lock_sequencer_sync_2ff.sv | 27 ++
 rtl/pll_lock_sequencer.sv | 117 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and status counter helpers.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_DEBOUNCE  = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  localparam int STAT_W = 8;

  // Status counters stick at all-ones rather than wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear, for bringing
// asynchronous level signals into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for a debounced lock, then releases the core
// reset; retries on lock timeout and re-sequences on loss of lock.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 742500,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20
) (
  input  logic              i_clk_74a,
  input  logic              i_reset_n,
  input  logic              i_pll_locked,
  input  logic              i_soft_reset,
  output logic              o_pll_rst,
  output logic              o_core_reset_n,
  output logic              o_lock_stable,
  output logic [1:0]        o_seq_state,
  output logic [STAT_W-1:0] o_timeout_count,
  output logic [STAT_W-1:0] o_relock_count
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic              w_locked_s;
  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pll_rst;
  logic              r_core_reset_n;
  logic              r_lock_stable;
  logic [STAT_W-1:0] r_timeout_count;
  logic [STAT_W-1:0] r_relock_count;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (i_clk_74a),
    .i_rst_n (i_reset_n),
    .i_d     (i_pll_locked),
    .o_q     (w_locked_s)
  );

  // Outputs are updated on the same edge as the state they belong to.
  always_ff @(posedge i_clk_74a or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= ST_RESET_PLL;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_core_reset_n  <= 1'b0;
      r_lock_stable   <= 1'b0;
      r_timeout_count <= '0;
      r_relock_count  <= '0;
    end else if (i_soft_reset) begin
      r_state        <= ST_RESET_PLL;
      r_cnt          <= '0;
      r_pll_rst      <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_lock_stable  <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_DEBOUNCE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state         <= ST_RESET_PLL;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_timeout_count <= sat_inc(r_timeout_count);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state        <= ST_RUN;
            r_cnt          <= '0;
            r_core_reset_n <= 1'b1;
            r_lock_stable  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (!w_locked_s) begin
            r_state        <= ST_RESET_PLL;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_core_reset_n <= 1'b0;
            r_lock_stable  <= 1'b0;
            r_relock_count <= sat_inc(r_relock_count);
          end
        end
      endcase
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_core_reset_n  = r_core_reset_n;
  assign o_lock_stable   = r_lock_stable;
  assign o_seq_state     = r_state;
  assign o_timeout_count = r_timeout_count;
  assign o_relock_count  = r_relock_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock/soft-reset
// traffic, every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic       lock_stable;
  logic [1:0] seq_state;
  logic [7:0] timeout_count;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0..3, edges spent in the phase, status tallies,
  // and a 2-deep FIFO of sampled lock values standing in for synchronizer delay.
  int m_phase, m_elapsed, m_tcnt, m_rcnt;
  int lk_q[$];

  pll_lock_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C), .CNT_W(8)
  ) dut (
    .i_clk_74a       (clk),
    .i_reset_n       (reset_n),
    .i_pll_locked    (pll_locked),
    .i_soft_reset    (soft_reset),
    .o_pll_rst       (pll_rst),
    .o_core_reset_n  (core_reset_n),
    .o_lock_stable   (lock_stable),
    .o_seq_state     (seq_state),
    .o_timeout_count (timeout_count),
    .o_relock_count  (relock_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_tcnt = 0; m_rcnt = 0;
    lk_q = '{0, 0};
  endtask

  task automatic model_step();
    int ls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ls = lk_q.pop_front();
    lk_q.push_back(int'(pll_locked));
    if (soft_reset) begin
      m_phase = 0; m_elapsed = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_elapsed++;
        if (m_elapsed == RST_C) begin m_phase = 1; m_elapsed = 0; end
      end
      1: begin
        if (ls == 1) begin m_phase = 2; m_elapsed = 0; end
        else begin
          m_elapsed++;
          if (m_elapsed == TO_C) begin
            m_phase = 0; m_elapsed = 0;
            if (m_tcnt < 255) m_tcnt++;
          end
        end
      end
      2: begin
        if (ls == 0) begin m_phase = 1; m_elapsed = 0; end
        else begin
          m_elapsed++;
          if (m_elapsed == ST_C) m_phase = 3;
        end
      end
      default: begin
        if (ls == 0) begin
          m_phase = 0; m_elapsed = 0;
          if (m_rcnt < 255) m_rcnt++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("seq_state", int'(seq_state), m_phase);
    check("pll_rst", int'(pll_rst), (m_phase == 0) ? 1 : 0);
    check("core_reset_n", int'(core_reset_n), (m_phase == 3) ? 1 : 0);
    check("lock_stable", int'(lock_stable), (m_phase == 3) ? 1 : 0);
    check("timeout_count", int'(timeout_count), m_tcnt);
    check("relock_count", int'(relock_count), m_rcnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int run_left;
    model_reset();
    @(negedge clk);
    compare_all();
    $display("reset state checked");

    // Scenario 1: no lock, three full retry periods
    reset_n = 1'b1;
    ticks(3 * (RST_C + TO_C));
    check("s1_timeouts", int'(timeout_count), 3);
    check("s1_core_reset_n", int'(core_reset_n), 0);
    $display("scenario 1: lock timeout retries done");

    // Scenario 2: lock arrives 5 cycles into WAIT_LOCK
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    ticks(RST_C);
    check("s2_pll_rst_low", int'(pll_rst), 0);
    ticks(5);
    pll_locked = 1'b1;
    ticks(3);
    check("s2_debounce_entry", int'(seq_state), 2);
    ticks(3);

    // Scenario 3: 3-cycle dropout mid-debounce, then full debounce again
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    ticks(10);
    check("s3_not_yet_run", int'(core_reset_n), 0);
    tick();
    check("s3_run_core", int'(core_reset_n), 1);
    check("s3_run_stable", int'(lock_stable), 1);
    check("s3_no_timeouts", int'(timeout_count), 0);
    $display("scenarios 2-3: debounce and restart done");

    // Scenario 4: lock loss in RUN, then recovery
    ticks(5);
    pll_locked = 1'b0;
    ticks(3);
    check("s4_pll_rst", int'(pll_rst), 1);
    check("s4_core_reset_n", int'(core_reset_n), 0);
    check("s4_relock", int'(relock_count), 1);
    pll_locked = 1'b1;
    ticks(RST_C + ST_C + 4);
    check("s4_back_to_run", int'(seq_state), 3);
    $display("scenario 4: relock done");

    // Scenario 5: soft_reset coincident with synchronized lock loss
    pll_locked = 1'b0;
    ticks(2);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("s5_state", int'(seq_state), 0);
    check("s5_relock_unchanged", int'(relock_count), 1);
    $display("scenario 5: soft reset priority done");

    // Scenario 6: timeout saturation, then async reset mid-WAIT_LOCK
    ticks(300 * (RST_C + TO_C));
    check("s6_saturated", int'(timeout_count), 255);
    for (int i = 0; i < 2 * (RST_C + TO_C) && m_phase != 1; i++) tick();
    ticks(5);
    check("s6_in_wait", int'(seq_state), 1);
    #2 reset_n = 1'b0;
    #1;
    check("s6_async_state", int'(seq_state), 0);
    check("s6_async_pll_rst", int'(pll_rst), 1);
    check("s6_async_core", int'(core_reset_n), 0);
    check("s6_async_stable", int'(lock_stable), 0);
    check("s6_async_tcnt", int'(timeout_count), 0);
    check("s6_async_rcnt", int'(relock_count), 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    $display("scenario 6: saturation and async reset done");

    // Random lock traffic with occasional soft resets
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        pll_locked = $urandom_range(0, 1) != 0;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
      end
      run_left--;
      soft_reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    soft_reset = 1'b0;
    $display("random phase: 4000 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
